md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide responder with HI/LO registers, sitting in EX.
- Executes the ops that the ID-stage decoder flags as multiply/divide class (mult, multu, div, divu, mthi, mtlo); mfhi/mflo read the hi/lo outputs.
- Drives the multi-cycle busy window and the ID-stage stall request that holds later multiply/divide-class instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX instruction is multiply/divide class; op/a/b valid this cycle.
- op  input  3  1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0 and 7 are no-op.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- id_multdiv  input  1  ID instruction is multiply/divide class (incl. mfhi/mflo).
- busy  output  1  multi-cycle op in progress.
- md_stall  output  1  stall request to the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result=0. Reset mid-operation aborts the op; no commit.
- Idle is busy=0; Run is busy=1, held by a 4-bit down-counter.
- Accept rule: start=1 and busy=0 at edge T.
  - mult/multu: compute the 64-bit product from a/b at T and store it in pending regs; counter=MULT_CYCLES; busy=1.
  - div/divu: quotient and remainder are computed at T and stored in pending regs; counter=DIV_CYCLES; busy=1.
  - mthi: hi<=a at T; no busy. mtlo: lo<=a at T; no busy.
  - op 0/7: ignored.
- Signedness:
  - mult/div use two's-complement operands.
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - multu/divu are unsigned.
  - Product: hi=[63:32], lo=[31:0]. Divide: lo=quotient, hi=remainder.
- Run: counter decrements each edge. On the edge where counter==1: hi/lo <= pending, busy<=0, counter<=0.
  - Net: busy is high for exactly N cycles after T.
  - The new hi/lo is visible in the first cycle busy is low.
- start while busy=1: ignored entirely, including mthi/mtlo. The stall prevents this; the bench asserts it never occurs.
- Divide by zero (b==0, div/divu): busy sequence runs normally; hi/lo unchanged at commit.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- md_stall = id_multdiv & (busy | start), combinational. No stall for non-multdiv ID instructions.
- hi/lo are registered outputs. mfhi in the commit-following cycle reads the new value.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- Defined: adds input port flush (1 bit). flush=1 at an edge clears busy and counter, discards the pending result, and leaves hi/lo unchanged. flush has priority over start in the same cycle, so that start is dropped. reset has priority over flush.
- Undefined: port absent; an accepted op always commits.

Test Plan:
- Reset held 2 cycles with stale state → busy=0, hi=0, lo=0 on the cycle after reset deasserts.
- mult a=0xFFFFFFFF, b=2 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1. div a=5, b=0 → hi/lo keep prior values after 10 busy cycles.
- id_multdiv=1 during the start cycle and each busy cycle → md_stall=1; md_stall=0 on the first non-busy cycle. id_multdiv=0 while busy → md_stall=0.
- mthi a=0x12345678, then next cycle mtlo a=0x9ABCDEF0 → hi/lo update one edge after each start; busy stays 0.
- reset asserted on the 3rd busy cycle of a div → busy=0, hi=lo=0, no later commit. With MDU_FLUSH_EN, flush in the same situation → busy=0, hi/lo retain prior values.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: latches the result at accept, holds busy for a
// fixed cycle count, then commits. Optional MDU_FLUSH_EN adds a flush input that aborts an op.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_multdiv,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  // Operand conditioning shared by multiply and divide
  logic        sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    a_ext = {{32{a_neg}}, a};
    b_ext = {{32{b_neg}}, b};
    prod  = a_ext * b_ext;
    // Divide on magnitudes so the -2^31 / -1 case wraps cleanly to 0x80000000
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    if (state_q == S_RUN) begin
      if (cnt_q == 4'd1) begin
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        state_d   = S_IDLE;
        cnt_d     = 4'd0;
        pend_hi_d = 32'd0;
        pend_lo_d = 32'd0;
        pend_wr_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          pend_hi_d = prod[63:32];
          pend_lo_d = prod[31:0];
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CNT;
          state_d   = S_RUN;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi_d = rem;
          pend_lo_d = quot;
          pend_wr_d = (b != 32'd0);
          cnt_d     = DIV_CNT;
          state_d   = S_RUN;
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
`ifdef MDU_FLUSH_EN
    // Flush drops both an in-flight commit and a same-cycle start
    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = 4'd0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = 32'd0;
      pend_lo_d = 32'd0;
      pend_wr_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = id_multdiv & (busy | start);

endmodule
